branch_resolve_ctrl: RTL and testbench

Tracks in-flight conditional-branch predictions from IF until they resolve in EX, and sequences misprediction recovery. It sits between the IF-stage direction predictor (1-bit/2-bit) and the PC/flush logic. It holds a small ordered queue of outstanding predictions and compares each one against the actual outcome. On a mismatch it issues exactly one flush/redirect and one `pred_wrong` update pulse to the predictor.

---
 rtl/brc_pkg.sv | 29 ++
 rtl/brc_fifo.sv | 62 ++++++
 rtl/branch_resolve_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and constants for the branch resolve controller and the
// IF-stage direction predictors.
package brc_pkg;

  localparam int BRC_PC_W = 32;

  // Conditional-branch encodings shared with the predictors
  localparam logic [6:0] BRC_OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] BRC_F3_BEQ     = 3'b000;
  localparam logic [2:0] BRC_F3_BNE     = 3'b001;

  typedef enum logic {
    TRACK   = 1'b0,
    RECOVER = 1'b1
  } brc_state_e;

  // One outstanding prediction: the direction guessed and the path not taken
  typedef struct packed {
    logic                predTaken;
    logic [BRC_PC_W-1:0] pcAlt;
  } brc_entry_t;

  function automatic logic brcIsCondBranch(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
    return (opcode == BRC_OPC_BRANCH) &&
           ((funct3 == BRC_F3_BEQ) || (funct3 == BRC_F3_BNE));
  endfunction

endpackage

// File: rtl/brc_fifo.sv
// Ordered circular buffer of outstanding predictions with push, pop and a
// whole-queue clear. Pushes while full and pops while empty are ignored.
module brc_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 33,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = (IDX_W > 3) ? IDX_W : 3,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && (count_q != '0);
  assign head_o  = mem_q[rdPtr_q[IDX_W-1:0]];

  // Write the incoming entry into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[IDX_W-1:0]] <= data_i;
    end
  end

  // Advance pointers and occupancy; clear empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
      if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight branch predictions from IF until EX resolves them and
// sequences a single-cycle flush/redirect on a misprediction.
// Optional macro BRC_STATS_EN adds saturating resolved/mispredict counters;
// without it the stat ports read as zero.
module branch_resolve_ctrl
  import brc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = BRC_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_is_branch,
  input  logic            if_pred_taken,
  input  logic [PC_W-1:0] if_pc_alt,
  input  logic            ex_valid,
  input  logic            ex_taken,
  output logic            full,
  output logic            pred_wrong,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            err_underflow,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispred
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  brc_state_e       state_q;
  logic             predWrong_q;
  logic             flush_q;
  logic             redirectValid_q;
  logic [PC_W-1:0]  redirectPc_q;
  logic             errUnderflow_q;

  brc_entry_t       pushEntry;
  brc_entry_t       headEntry;
  logic [CNT_W-1:0] count;
  logic             fifoFull;
  logic             inTrack;
  logic             doPush;
  logic             doPop;
  logic             mismatch;
  logic             underflow;

  assign inTrack   = (state_q == TRACK);
  assign doPush    = if_is_branch && !stall && !fifoFull && inTrack;
  assign doPop     = ex_valid && (count != '0) && inTrack;
  assign mismatch  = doPop && (ex_taken != headEntry.predTaken);
  assign underflow = ex_valid && (count == '0) && inTrack;

  // Pack the IF-side prediction into a queue entry
  always_comb begin
    pushEntry           = '0;
    pushEntry.predTaken = if_pred_taken;
    pushEntry.pcAlt     = BRC_PC_W'(if_pc_alt);
  end

  brc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(brc_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (doPush && !mismatch),
    .pop_i   (doPop),
    .clear_i (state_q == RECOVER),
    .data_i  (pushEntry),
    .head_o  (headEntry),
    .count_o (count),
    .full_o  (fifoFull)
  );

  // Recovery FSM with registered pulses; a wrong-path push is dropped above
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= TRACK;
      predWrong_q     <= 1'b0;
      flush_q         <= 1'b0;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= '0;
      errUnderflow_q  <= 1'b0;
    end else begin
      predWrong_q     <= 1'b0;
      flush_q         <= 1'b0;
      redirectValid_q <= 1'b0;
      case (state_q)
        TRACK: begin
          if (underflow) errUnderflow_q <= 1'b1;
          if (mismatch) begin
            state_q         <= RECOVER;
            predWrong_q     <= 1'b1;
            flush_q         <= 1'b1;
            redirectValid_q <= 1'b1;
            redirectPc_q    <= PC_W'(headEntry.pcAlt);
          end
        end
        RECOVER: state_q <= TRACK;
        default: state_q <= TRACK;
      endcase
    end
  end

  assign full           = fifoFull;
  assign pred_wrong     = predWrong_q;
  assign flush          = flush_q;
  assign redirect_valid = redirectValid_q;
  assign redirect_pc    = redirectPc_q;
  assign err_underflow  = errUnderflow_q;

`ifdef BRC_STATS_EN
  logic [15:0] statBranches_q, statBranches_d;
  logic [15:0] statMispred_q, statMispred_d;

  // Saturating counts of resolved branches and mispredictions
  always_comb begin
    statBranches_d = statBranches_q;
    statMispred_d  = statMispred_q;
    if (doPop && (statBranches_q != 16'hFFFF)) statBranches_d = statBranches_q + 16'd1;
    if (mismatch && (statMispred_q != 16'hFFFF)) statMispred_d = statMispred_q + 16'd1;
  end

  // Register the statistics counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      statBranches_q <= '0;
      statMispred_q  <= '0;
    end else begin
      statBranches_q <= statBranches_d;
      statMispred_q  <= statMispred_d;
    end
  end

  assign stat_branches = statBranches_q;
  assign stat_mispred  = statMispred_q;
`else
  assign stat_branches = 16'h0000;
  assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic            if_is_branch;
  logic            if_pred_taken;
  logic [PC_W-1:0] if_pc_alt;
  logic            ex_valid;
  logic            ex_taken;
  logic            full;
  logic            pred_wrong;
  logic            flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            err_underflow;
  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispred;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [PC_W:0]   mQ[$];
  bit              mRec;
  bit              mPulse;
  logic [PC_W-1:0] mRedir;
  bit              mErr;
  int              mStatB;
  int              mStatM;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .if_is_branch   (if_is_branch),
    .if_pred_taken  (if_pred_taken),
    .if_pc_alt      (if_pc_alt),
    .ex_valid       (ex_valid),
    .ex_taken       (ex_taken),
    .full           (full),
    .pred_wrong     (pred_wrong),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err_underflow  (err_underflow),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    bit pushOk;
    logic [PC_W:0] e;
    if (!rst_n) begin
      mQ.delete();
      mRec = 0; mPulse = 0; mRedir = '0; mErr = 0; mStatB = 0; mStatM = 0;
    end else if (mRec) begin
      mRec = 0; mPulse = 0;
      mQ.delete();
    end else begin
      mPulse = 0;
      pushOk = if_is_branch && !stall && (mQ.size() < DEPTH);
      if (ex_valid) begin
        if (mQ.size() == 0) mErr = 1;
        else begin
          e = mQ.pop_front();
          if (mStatB < 65535) mStatB++;
          if (e[PC_W] != ex_taken) begin
            mPulse = 1; mRedir = e[PC_W-1:0]; mRec = 1; pushOk = 0;
            if (mStatM < 65535) mStatM++;
          end
        end
      end
      if (pushOk) mQ.push_back({if_pred_taken, if_pc_alt});
    end
  endtask

  function automatic logic [68:0] exp_vec();
    logic [15:0] sb, sm;
`ifdef BRC_STATS_EN
    sb = 16'(mStatB); sm = 16'(mStatM);
`else
    sb = 16'h0; sm = 16'h0;
`endif
    return {(mQ.size() == DEPTH), mPulse, mPulse, mPulse, mRedir, mErr, sb, sm};
  endfunction

  function automatic logic [68:0] obs_vec();
    return {full, pred_wrong, flush, redirect_valid, redirect_pc, err_underflow,
            stat_branches, stat_mispred};
  endfunction

  // Drive one cycle of inputs, clock it, update the model, then settle
  task automatic cyc(input logic r, input logic st, input logic br, input logic pt,
                     input logic [PC_W-1:0] alt, input logic ev, input logic et);
    rst_n = r; stall = st; if_is_branch = br; if_pred_taken = pt;
    if_pc_alt = alt; ex_valid = ev; ex_taken = et;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, 1, 32'h1234, 1, 1);
    nChecks++;
    if ({full, pred_wrong, flush, redirect_valid, err_underflow} !== 5'b0)
      $display("[TB] FAIL reset_flags got=%b exp=00000",
               {full, pred_wrong, flush, redirect_valid, err_underflow});
    else nPass++;
    nChecks++;
    if (redirect_pc !== 32'h0) $display("[TB] FAIL reset_pc got=%h exp=0", redirect_pc);
    else nPass++;
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
  endtask

  task automatic test_match_pop();
    logic [15:0] expB;
`ifdef BRC_STATS_EN
    expB = 16'd1;
`else
    expB = 16'd0;
`endif
    cyc(1, 0, 1, 1, 32'h40, 0, 0);
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL match_push got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if ({pred_wrong, flush, redirect_valid} !== 3'b000)
      $display("[TB] FAIL match_no_pulse got=%b exp=000", {pred_wrong, flush, redirect_valid});
    else nPass++;
    nChecks++;
    if (stat_branches !== expB) $display("[TB] FAIL match_stat got=%0d exp=%0d", stat_branches, expB);
    else nPass++;
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if (err_underflow !== 1'b1) $display("[TB] FAIL match_empty_after got=%b exp=1", err_underflow);
    else nPass++;
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL match_model got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
  endtask

  task automatic test_mispredict();
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 1, 0, 32'h80, 0, 0);
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if ({pred_wrong, flush, redirect_valid} !== 3'b111)
      $display("[TB] FAIL mispred_pulse got=%b exp=111", {pred_wrong, flush, redirect_valid});
    else nPass++;
    nChecks++;
    if (redirect_pc !== 32'h80) $display("[TB] FAIL mispred_pc got=%h exp=80", redirect_pc);
    else nPass++;
    cyc(1, 0, 0, 0, '0, 0, 0);
    nChecks++;
    if ({pred_wrong, flush, redirect_valid} !== 3'b000)
      $display("[TB] FAIL mispred_one_cycle got=%b exp=000", {pred_wrong, flush, redirect_valid});
    else nPass++;
    nChecks++;
    if (redirect_pc !== 32'h80) $display("[TB] FAIL mispred_pc_hold got=%h exp=80", redirect_pc);
    else nPass++;
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL mispred_model got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
  endtask

  task automatic test_full();
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 1, 1, 32'h100, 0, 0);
    cyc(1, 0, 1, 1, 32'h104, 0, 0);
    nChecks++;
    if (full !== 1'b1) $display("[TB] FAIL full_set got=%b exp=1", full);
    else nPass++;
    cyc(1, 0, 1, 0, 32'h108, 0, 0);
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL full_drop got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
    cyc(1, 0, 1, 1, 32'h10C, 1, 1);
    cyc(1, 0, 1, 1, 32'h110, 1, 1);
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL full_pop_push got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
    cyc(1, 0, 1, 1, 32'h114, 0, 0);
    nChecks++;
    if (full !== 1'b1) $display("[TB] FAIL full_refill got=%b exp=1", full);
    else nPass++;
    repeat (3) cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL full_drain got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
  endtask

  task automatic test_mispred_with_push();
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 1, 0, 32'h200, 0, 0);
    cyc(1, 0, 1, 1, 32'h204, 0, 0);
    cyc(1, 0, 1, 1, 32'h208, 1, 1);
    nChecks++;
    if (redirect_pc !== 32'h200) $display("[TB] FAIL wrongpath_pc got=%h exp=200", redirect_pc);
    else nPass++;
    cyc(1, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if (err_underflow !== 1'b1) $display("[TB] FAIL wrongpath_empty got=%b exp=1", err_underflow);
    else nPass++;
    nChecks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL wrongpath_model got=%h exp=%h", obs_vec(), exp_vec());
    else nPass++;
  endtask

  task automatic test_ex_valid_in_recover();
    cyc(0, 0, 0, 0, '0, 0, 0);
    cyc(1, 0, 1, 1, 32'h300, 0, 0);
    cyc(1, 0, 1, 0, 32'h304, 0, 0);
    cyc(1, 0, 0, 0, '0, 1, 0);
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if ({pred_wrong, flush, redirect_valid, err_underflow} !== 4'b0000)
      $display("[TB] FAIL recover_ignore got=%b exp=0000",
               {pred_wrong, flush, redirect_valid, err_underflow});
    else nPass++;
    nChecks++;
    if (redirect_pc !== 32'h300) $display("[TB] FAIL recover_pc got=%h exp=300", redirect_pc);
    else nPass++;
  endtask

  task automatic test_reset_in_recover();
    cyc(1, 0, 1, 0, 32'h400, 0, 0);
    cyc(1, 0, 0, 0, '0, 1, 1);
    nChecks++;
    if (flush !== 1'b1) $display("[TB] FAIL rstrec_pulse got=%b exp=1", flush);
    else nPass++;
    cyc(0, 0, 0, 0, '0, 0, 0);
    nChecks++;
    if (obs_vec() !== 69'h0) $display("[TB] FAIL rstrec_clear got=%h exp=0", obs_vec());
    else nPass++;
    cyc(1, 0, 0, 0, '0, 1, 0);
    nChecks++;
    if (err_underflow !== 1'b1) $display("[TB] FAIL rstrec_empty got=%b exp=1", err_underflow);
    else nPass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 1), $urandom_range(0, 1));
      nChecks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL random_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else nPass++;
    end
  endtask

  initial begin
    rst_n = 0; stall = 0; if_is_branch = 0; if_pred_taken = 0;
    if_pc_alt = '0; ex_valid = 0; ex_taken = 0;
    test_reset();
    test_match_pop();
    test_mispredict();
    test_full();
    test_mispred_with_push();
    test_ex_valid_in_recover();
    test_reset_in_recover();
    test_random();
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
